// File: rtl/neuron_act_if.sv
// rtl/neuron_act_if.sv - result stream from the activation FIFO to the next layer's MAC
interface neuron_act_if #(
  parameter int IDX_W = 3
);
  logic             out_valid;
  logic [15:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/neuron_act.sv
// rtl/neuron_act.sv - saturating bias add, piecewise-linear sigmoid and FWFT output FIFO
module neuron_act #(
  parameter int DEPTH       = 4,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done,
  input  logic [15:0]            mac_in,
  input  logic [15:0]            bias,
  neuron_act_if.master           ob,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Stage 1: saturating bias add and neuron tagging
  logic signed [16:0] sum17;
  logic [15:0]        sat_sum;
  logic               s1_valid;
  logic [15:0]        s1_sum;
  logic [IDX_W-1:0]   s1_idx;
  logic [IDX_W-1:0]   idx_cnt;

  assign sum17 = {mac_in[15], mac_in} + {bias[15], bias};

  always_comb begin
    sat_sum = sum17[15:0];
    if (sum17[16] != sum17[15]) begin
      sat_sum = sum17[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_idx   <= '0;
      idx_cnt  <= '0;
    end else begin
      s1_valid <= done;
      if (done) begin
        s1_sum  <= sat_sum;
        s1_idx  <= idx_cnt;
        idx_cnt <= (idx_cnt == LAST_IDX) ? '0 : idx_cnt + IDX_W'(1);
      end
    end
  end

  // Stage 2: magnitude, sign and region select; -32768 folds onto +32767
  logic [15:0]      s1_mag;
  logic [1:0]       s1_region;
  logic             s2_valid;
  logic [10:2]      s2_mag;
  logic             s2_neg;
  logic [1:0]       s2_region;
  logic [IDX_W-1:0] s2_idx;

  always_comb begin
    s1_mag = s1_sum;
    if (s1_sum[15]) begin
      s1_mag = (s1_sum == 16'h8000) ? 16'h7FFF : (~s1_sum + 16'd1);
    end
  end

  always_comb begin
    s1_region = 2'd0;
    if (s1_mag >= 16'd1280) begin
      s1_region = 2'd3;
    end else if (s1_mag >= 16'd608) begin
      s1_region = 2'd2;
    end else if (s1_mag >= 16'd256) begin
      s1_region = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_mag    <= '0;
      s2_neg    <= 1'b0;
      s2_region <= '0;
      s2_idx    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mag    <= s1_mag[10:2];
        s2_neg    <= s1_sum[15];
        s2_region <= s1_region;
        s2_idx    <= s1_idx;
      end
    end
  end

  // Stage 3: segment evaluation; only magnitude bits each segment can reach are kept
  logic [8:0] y_pos;
  logic [8:0] y_val;

  always_comb begin
    case (s2_region)
      2'd3:    y_pos = 9'd256;
      2'd2:    y_pos = {3'b000, s2_mag[10:5]} + 9'd216;
      2'd1:    y_pos = {2'b00, s2_mag[9:3]} + 9'd160;
      default: y_pos = {3'b000, s2_mag[7:2]} + 9'd128;
    endcase
    y_val = s2_neg ? (9'd256 - y_pos) : y_pos;
  end

  // Output FIFO, first-word fall-through
  logic [8:0]       mem_data [DEPTH];
  logic [IDX_W-1:0] mem_idx  [DEPTH];
  logic             mem_last [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [8:0]       hold_data;
  logic [IDX_W-1:0] hold_idx;
  logic             hold_last;
  logic             push;
  logic             pop;
  logic             full;
  logic             do_write;

  assign push     = s2_valid;
  assign pop      = ob.out_valid & ob.out_ready;
  assign full     = (fifo_count == FULL_CNT);
  // When full, a simultaneous pop frees the slot the write lands in
  assign do_write = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_data[wr_ptr] <= y_val;
      mem_idx[wr_ptr]  <= s2_idx;
      mem_last[wr_ptr] <= (s2_idx == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      hold_data  <= '0;
      hold_idx   <= '0;
      hold_last  <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        hold_data <= mem_data[rd_ptr];
        hold_idx  <= mem_idx[rd_ptr];
        hold_last <= mem_last[rd_ptr];
      end
      case ({do_write, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Empty FIFO keeps presenting the last head that was popped
  assign ob.out_valid = (fifo_count != '0);
  assign ob.out_data  = {7'b0, (ob.out_valid ? mem_data[rd_ptr] : hold_data)};
  assign ob.out_idx   = ob.out_valid ? mem_idx[rd_ptr]  : hold_idx;
  assign ob.out_last  = ob.out_valid ? mem_last[rd_ptr] : hold_last;

  assign busy = s1_valid | s2_valid | ob.out_valid;

endmodule

// File: tb/tb_neuron_act.sv
// tb/tb_neuron_act.sv - vector, corner-sequence and randomized checks of neuron_act
module tb_neuron_act;

  localparam int DEPTH = 4;
  localparam int NUM   = 8;
  localparam int IDX_W = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        done = 1'b0;
  logic [15:0] mac_in = '0;
  logic [15:0] bias = '0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        overflow;
  logic        busy;

  neuron_act_if #(.IDX_W(IDX_W)) stream ();

  neuron_act #(.DEPTH(DEPTH), .NUM_NEURONS(NUM), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .done       (done),
    .mac_in     (mac_in),
    .bias       (bias),
    .ob         (stream),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] mac;
    logic [15:0] bias;
    int          exp;
  } vec_t;

  typedef struct {
    int due;
    int data;
    int idx;
  } pend_t;

  typedef struct {
    int data;
    int idx;
  } ent_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    done = 1'b0;
    stream.out_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Sigmoid from the segment definitions using plain integer arithmetic
  function automatic int ref_act(input int m, input int b);
    int s, a, yp;
    s = m + b;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    if (a >= 1280)     yp = 256;
    else if (a >= 608) yp = a / 32 + 216;
    else if (a >= 256) yp = a / 8 + 160;
    else               yp = a / 4 + 128;
    return (s < 0) ? 256 - yp : yp;
  endfunction

  vec_t  vecs[10];
  int    seen_idx[$];
  int    seen_last[$];
  pend_t pend[$];
  ent_t  fq[$];
  ent_t  fe;
  pend_t pe;
  int    exp_ovf[4];
  int    mi, mo, cyc, m, b;
  logic  pop_m;

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 128};
    vecs[1] = '{16'h0100, 16'h0000, 192};
    vecs[2] = '{16'hFF00, 16'h0000, 64};
    vecs[3] = '{16'h0200, 16'h0000, 224};
    vecs[4] = '{16'h0260, 16'h0000, 235};
    vecs[5] = '{16'h0600, 16'h0000, 256};
    vecs[6] = '{16'hFA00, 16'h0000, 0};
    vecs[7] = '{16'h8000, 16'h0000, 0};
    vecs[8] = '{16'h7F00, 16'h0200, 256};
    vecs[9] = '{16'h8100, 16'hFE00, 0};

    stream.out_ready = 1'b0;
    reset_dut();
    check("rst_valid", 32'(stream.out_valid), 0);
    check("rst_data", 32'(stream.out_data), 0);
    check("rst_idx", 32'(stream.out_idx), 0);
    check("rst_last", 32'(stream.out_last), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);

    // Single-result vectors: latency, value, tag, pop and hold-after-empty
    for (int i = 0; i < 10; i++) begin
      done = 1'b1; mac_in = vecs[i].mac; bias = vecs[i].bias;
      tick();
      done = 1'b0;
      check("vec_busy", 32'(busy), 1);
      tick();
      check("vec_lat2_valid", 32'(stream.out_valid), 0);
      tick();
      check("vec_valid", 32'(stream.out_valid), 1);
      check("vec_data", 32'(stream.out_data), 32'(vecs[i].exp));
      check("vec_idx", 32'(stream.out_idx), 32'(i % NUM));
      check("vec_last", 32'(stream.out_last), 32'((i % NUM) == NUM - 1));
      check("vec_count", 32'(fifo_count), 1);
      stream.out_ready = 1'b1;
      tick();
      stream.out_ready = 1'b0;
      check("vec_pop_valid", 32'(stream.out_valid), 0);
      check("vec_hold_data", 32'(stream.out_data), 32'(vecs[i].exp));
    end

    // Index wrap over 9 back-to-back results with a consumer always ready
    reset_dut();
    stream.out_ready = 1'b1;
    seen_idx.delete();
    seen_last.delete();
    for (int c = 0; c < 20; c++) begin
      done = (c < 9);
      mac_in = 16'h0000;
      bias = 16'h0000;
      tick();
      if (stream.out_valid) begin
        seen_idx.push_back(int'(stream.out_idx));
        seen_last.push_back(int'(stream.out_last));
      end
    end
    done = 1'b0;
    stream.out_ready = 1'b0;
    check("wrap_count", 32'(seen_idx.size()), 9);
    for (int k = 0; k < seen_idx.size() && k < 9; k++) begin
      check("wrap_idx", 32'(seen_idx[k]), 32'(k % NUM));
      check("wrap_last", 32'(seen_last[k]), 32'((k % NUM) == NUM - 1));
    end

    // Overflow: five results into a four-entry FIFO, then push+pop while full
    reset_dut();
    exp_ovf = '{128, 192, 64, 224};
    for (int k = 0; k < 5; k++) begin
      done = 1'b1;
      case (k)
        0: mac_in = 16'h0000;
        1: mac_in = 16'h0100;
        2: mac_in = 16'hFF00;
        3: mac_in = 16'h0200;
        default: mac_in = 16'h0260;
      endcase
      tick();
    end
    done = 1'b0;
    tick();
    tick();
    check("ovf_count", 32'(fifo_count), 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_head", 32'(stream.out_data), 128);
    done = 1'b1; mac_in = 16'h0600;
    tick();
    done = 1'b0;
    tick();
    stream.out_ready = 1'b1;
    tick();
    stream.out_ready = 1'b0;
    check("pp_count", 32'(fifo_count), 4);
    check("pp_flag", 32'(overflow), 1);
    for (int k = 0; k < 4; k++) begin
      check("pp_order", 32'(stream.out_data), (k < 3) ? 32'(exp_ovf[k + 1]) : 32'd256);
      stream.out_ready = 1'b1;
      tick();
      stream.out_ready = 1'b0;
    end
    check("pp_drained", 32'(stream.out_valid), 0);

    // Asynchronous reset with two buffered and two in flight
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      done = 1'b1; mac_in = 16'(k * 300);
      tick();
    end
    done = 1'b0;
    check("mid_count", 32'(fifo_count), 2);
    check("mid_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(stream.out_valid), 0);
    check("arst_count", 32'(fifo_count), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_data", 32'(stream.out_data), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("arst_quiet", 32'(stream.out_valid), 0);
    end

    // Randomized traffic against a cycle-level queue model
    reset_dut();
    pend.delete();
    fq.delete();
    mi = 0;
    mo = 0;
    cyc = 0;
    for (int t = 0; t < 400; t++) begin
      done = ($urandom_range(0, 9) < 6);
      stream.out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) m = int'($signed(16'($urandom())));
      else m = int'($urandom_range(0, 4000)) - 2000;
      if ($urandom_range(0, 7) == 0) b = int'($signed(16'($urandom())));
      else b = int'($urandom_range(0, 1200)) - 600;
      mac_in = 16'(m);
      bias = 16'(b);

      pop_m = (fq.size() > 0) && stream.out_ready;
      if (pop_m) void'(fq.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        pe = pend.pop_front();
        if (fq.size() == DEPTH) begin
          mo = 1;
        end else begin
          fe.data = pe.data;
          fe.idx = pe.idx;
          fq.push_back(fe);
        end
      end
      if (done) begin
        pe.due = cyc + 2;
        pe.data = ref_act(int'($signed(mac_in)), int'($signed(bias)));
        pe.idx = mi;
        pend.push_back(pe);
        mi = (mi + 1) % NUM;
      end

      tick();
      cyc++;

      check("rnd_valid", 32'(stream.out_valid), 32'(fq.size() > 0));
      check("rnd_count", 32'(fifo_count), 32'(fq.size()));
      check("rnd_ovf", 32'(overflow), 32'(mo));
      check("rnd_busy", 32'(busy), 32'((fq.size() > 0) || (pend.size() > 0)));
      if (fq.size() > 0) begin
        check("rnd_data", 32'(stream.out_data), 32'(fq[0].data));
        check("rnd_idx", 32'(stream.out_idx), 32'(fq[0].idx));
        check("rnd_last", 32'(stream.out_last), 32'(fq[0].idx == NUM - 1));
      end
    end
    done = 1'b0;
    stream.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_act.md
Name: neuron_act

Overview:
- Activation stage directly downstream of the MAC.
- On each MAC `done` pulse it captures the 16-bit partial sum, adds a per-neuron bias with saturation, applies a piecewise-linear sigmoid, and writes the result into a small output FIFO.
- The FIFO output (`out_valid`/`out_data`) drives the next layer's MAC `sig_rdy`/`mac_in`.
- Each result is tagged with a neuron index that wraps per layer.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, ≥2)
- NUM_NEURONS, 8, neurons per layer; index wraps after NUM_NEURONS-1
- IDX_W, 3, width of neuron index (ceil(log2(NUM_NEURONS)), ≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- done  in  1  MAC done pulse; mac_in and bias valid in the same cycle
- mac_in  in  16  signed Q8.8 partial sum from MAC
- bias  in  16  signed Q8.8 bias for the current neuron
- out_ready  in  1  consumer accepts the FIFO head this cycle
- out_valid  out  1  FIFO non-empty
- out_data  out  16  Q8.8 sigmoid result at FIFO head, range 0..256
- out_idx  out  IDX_W  neuron index of FIFO head
- out_last  out  1  head is neuron NUM_NEURONS-1
- fifo_count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- busy  out  1  any pipeline stage valid or FIFO non-empty

Behaviour:
- Reset (async, reset=0):
  - all pipeline valids, FIFO pointers, fifo_count, index counter, overflow = 0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
  - Reset mid-operation discards all in-flight and buffered data.
- Stage 1 (edge where done=1):
  - s1 = sat16(mac_in + bias), using a 17-bit signed add.
  - Saturation clamps to 32767 / -32768.
  - s1_idx = index counter; the counter then increments, wrapping NUM_NEURONS-1 → 0.
- Stage 2:
  - a = |s1|; -32768 maps to 32767.
  - neg = sign(s1).
  - region: R3 if a≥1280; R2 if 608≤a<1280; R1 if 256≤a<608; R0 otherwise.
- Stage 3, y+ for positive input:
  - R3: 256
  - R2: (a>>5)+216
  - R1: (a>>3)+160
  - R0: (a>>2)+128
- Stage 3, result:
  - Output is y = neg ? 256-y+ : y+.
  - The result is written to the FIFO at the stage-3 edge.
- Latency:
  - The result is in the FIFO after the 3rd rising edge counting the capture edge.
  - out_valid rises after that edge if the FIFO was empty.
- Throughput:
  - done may be asserted every cycle; the pipeline never stalls.
- FIFO:
  - FWFT: out_data/out_idx/out_last show the head whenever out_valid=1.
  - Pop occurs on an edge with out_valid=1 and out_ready=1.
  - out_ready while empty is ignored.
  - Pointers wrap modulo DEPTH.
- Push and pop on the same edge:
  - count is unchanged and no overflow, even when full.
- Push while full without pop:
  - the result is dropped and overflow sets to 1.
  - overflow clears only on reset.
- out_data/out_idx/out_last while empty hold their last value (0 after reset).

Test Plan:
- Reset then single done with mac_in=0x0000, bias=0 → after 3 edges out_valid=1, out_data=128, out_idx=0, fifo_count=1; pop with out_ready → out_valid=0.
- Region points, bias=0:
  - mac_in 256 → 192; -256 → 64; 512 → 224; 608 → 235.
  - mac_in 1536 → 256; -1536 → 0; 0x8000 → 0.
- Saturation: mac_in=0x7F00, bias=0x0200 → s1=32767 → 256; mac_in=0x8100, bias=0xFE00 → 0.
- Index wrap: 9 back-to-back done pulses with out_ready=1 → out_idx 0..7,0; out_last=1 only on idx 7.
- Overflow: out_ready=0, 5 done pulses with DEPTH=4 → fifo_count=4, overflow=1, the first 4 results retained in order.
  - Then a push and pop on the same edge while full → count stays 4, and overflow stays 1 with no new drop.
- Async reset asserted mid-pipeline with 2 in flight and 2 buffered → outputs clear immediately; no results appear after release.
